// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match controller and display path.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } game_state_t;

  localparam int SCORE_W      = 4;
  localparam int X_RESOLUTION = 640;
  localparam int Y_RESOLUTION = 480;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one cycle of 'rise' per low-to-high transition of 'level'.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match controller: serve/play/point sequencing, scores and winner.
// state | meaning
// IDLE  | after reset, waiting for a start edge
// SERVE | ball re-centered, serve countdown running
// PLAY  | ball in motion, watching point edges
// POINT | one cycle to test the updated score for a win
// OVER  | match decided, scores/winner held until start edge
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               player1_point,
  input  logic               player2_point,
  output logic               game_on,
  output logic               ball_reset_n,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  localparam int                 CNT_W      = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  game_state_t        cur_state, nxt_state;
  logic [CNT_W-1:0]   serve_cnt, serve_cnt_nxt;
  logic [SCORE_W-1:0] score1_nxt, score2_nxt;
  logic [1:0]         winner_nxt;
  logic               serve_entry;
  logic               start_rise, p1_rise, p2_rise;

  rise_detect u_start (.clk(clk), .reset(reset), .level(start_btn),     .rise(start_rise));
  rise_detect u_p1    (.clk(clk), .reset(reset), .level(player1_point), .rise(p1_rise));
  rise_detect u_p2    (.clk(clk), .reset(reset), .level(player2_point), .rise(p2_rise));

  always_comb begin
    nxt_state     = cur_state;
    score1_nxt    = score1;
    score2_nxt    = score2;
    winner_nxt    = winner;
    serve_cnt_nxt = serve_cnt;
    case (cur_state)
      IDLE, OVER: begin
        if (start_rise) begin
          nxt_state  = SERVE;
          score1_nxt = '0;
          score2_nxt = '0;
          winner_nxt = WIN_NONE;
        end
      end
      SERVE: begin
        if (serve_cnt == '0) nxt_state = PLAY;
        else                 serve_cnt_nxt = serve_cnt - 1'b1;
      end
      PLAY: begin
        // Simultaneous points are a replay: no score, straight back to serve.
        if (p1_rise && p2_rise) begin
          nxt_state = SERVE;
        end else if (p1_rise) begin
          nxt_state  = POINT;
          score1_nxt = score1 + 1'b1;
        end else if (p2_rise) begin
          nxt_state  = POINT;
          score2_nxt = score2 + 1'b1;
        end
      end
      POINT: begin
        if (score1 == WIN_VAL) begin
          nxt_state  = OVER;
          winner_nxt = WIN_P1;
        end else if (score2 == WIN_VAL) begin
          nxt_state  = OVER;
          winner_nxt = WIN_P2;
        end else begin
          nxt_state = SERVE;
        end
      end
      default: nxt_state = IDLE;
    endcase
    serve_entry = (nxt_state == SERVE) && (cur_state != SERVE);
    if (serve_entry) serve_cnt_nxt = SERVE_LOAD;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state    <= IDLE;
      serve_cnt    <= '0;
      score1       <= '0;
      score2       <= '0;
      winner       <= WIN_NONE;
      game_on      <= 1'b0;
      ball_reset_n <= 1'b1;
    end else begin
      cur_state    <= nxt_state;
      serve_cnt    <= serve_cnt_nxt;
      score1       <= score1_nxt;
      score2       <= score2_nxt;
      winner       <= winner_nxt;
      game_on      <= (nxt_state == PLAY);
      ball_reset_n <= ~serve_entry;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed vector table, reset sequence, random run vs model.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  localparam int WS = 3;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset, start_btn, player1_point, player2_point;
  logic       game_on, ball_reset_n;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  logic [2:0] state;

  pong_game_ctrl #(.WIN_SCORE(WS), .SERVE_DELAY(SD)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn),
    .player1_point(player1_point), .player2_point(player2_point),
    .game_on(game_on), .ball_reset_n(ball_reset_n),
    .score1(score1), .score2(score2), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: match phase plus remaining serve cycles.
  game_state_t m_st;
  int  m_s1, m_s2, m_w, m_left;
  bit  m_ps, m_pp1, m_pp2, m_go, m_brn;

  typedef struct {
    bit s, a, b;
    int st, s1, s2, w, go, brn;
  } vec_t;

  vec_t vecs[34];

  function automatic vec_t v(bit s, bit a, bit b, game_state_t st, int s1, int s2, int w, int go, int brn);
    vec_t r;
    r.s = s; r.a = a; r.b = b;
    r.st = int'(st); r.s1 = s1; r.s2 = s2; r.w = w; r.go = go; r.brn = brn;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = IDLE; m_s1 = 0; m_s2 = 0; m_w = 0; m_left = 0;
    m_ps = 0; m_pp1 = 0; m_pp2 = 0; m_go = 0; m_brn = 1;
  endtask

  task automatic model_step(input bit s, input bit a, input bit b);
    bit se, e1, e2;
    game_state_t prev;
    se = s && !m_ps; e1 = a && !m_pp1; e2 = b && !m_pp2;
    m_ps = s; m_pp1 = a; m_pp2 = b;
    prev = m_st;
    case (m_st)
      IDLE, OVER: if (se) begin m_s1 = 0; m_s2 = 0; m_w = 0; m_st = SERVE; m_left = SD; end
      SERVE: begin m_left--; if (m_left == 0) m_st = PLAY; end
      PLAY: begin
        if (e1 && e2) begin m_st = SERVE; m_left = SD; end
        else if (e1) begin m_s1++; m_st = POINT; end
        else if (e2) begin m_s2++; m_st = POINT; end
      end
      default: begin
        if (m_s1 == WS) begin m_w = 1; m_st = OVER; end
        else if (m_s2 == WS) begin m_w = 2; m_st = OVER; end
        else begin m_st = SERVE; m_left = SD; end
      end
    endcase
    m_go  = (m_st == PLAY);
    m_brn = !(m_st == SERVE && prev != SERVE);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"},        int'(state),        int'(m_st));
    check({tag, ".score1"},       int'(score1),       m_s1);
    check({tag, ".score2"},       int'(score2),       m_s2);
    check({tag, ".winner"},       int'(winner),       m_w);
    check({tag, ".game_on"},      int'(game_on),      int'(m_go));
    check({tag, ".ball_reset_n"}, int'(ball_reset_n), int'(m_brn));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".state"},        int'(state),        int'(IDLE));
    check({tag, ".score1"},       int'(score1),       0);
    check({tag, ".score2"},       int'(score2),       0);
    check({tag, ".winner"},       int'(winner),       0);
    check({tag, ".game_on"},      int'(game_on),      0);
    check({tag, ".ball_reset_n"}, int'(ball_reset_n), 1);
  endtask

  task automatic step(input bit s, input bit a, input bit b);
    start_btn = s; player1_point = a; player2_point = b;
    @(posedge clk);
    #1;
    model_step(s, a, b);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #1;
    check_reset_vals(tag);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    bit rs, ra, rb;
    // start, p1, p2 -> state, score1, score2, winner, game_on, ball_reset_n
    vecs[0]  = v(0,0,0, IDLE,  0,0,0, 0,1);
    vecs[1]  = v(1,0,0, SERVE, 0,0,0, 0,0);
    vecs[2]  = v(1,0,0, SERVE, 0,0,0, 0,1);
    vecs[3]  = v(0,0,0, SERVE, 0,0,0, 0,1);
    vecs[4]  = v(0,0,0, SERVE, 0,0,0, 0,1);
    vecs[5]  = v(0,0,0, PLAY,  0,0,0, 1,1);
    vecs[6]  = v(0,1,0, POINT, 1,0,0, 0,1);
    vecs[7]  = v(0,1,0, SERVE, 1,0,0, 0,0);
    vecs[8]  = v(0,1,0, SERVE, 1,0,0, 0,1);
    vecs[9]  = v(0,0,0, SERVE, 1,0,0, 0,1);
    vecs[10] = v(0,0,0, SERVE, 1,0,0, 0,1);
    vecs[11] = v(0,0,0, PLAY,  1,0,0, 1,1);
    vecs[12] = v(0,1,1, SERVE, 1,0,0, 0,0);
    vecs[13] = v(0,1,1, SERVE, 1,0,0, 0,1);
    vecs[14] = v(0,0,0, SERVE, 1,0,0, 0,1);
    vecs[15] = v(1,0,0, SERVE, 1,0,0, 0,1);
    vecs[16] = v(0,0,0, PLAY,  1,0,0, 1,1);
    vecs[17] = v(1,0,0, PLAY,  1,0,0, 1,1);
    vecs[18] = v(0,0,1, POINT, 1,1,0, 0,1);
    vecs[19] = v(0,0,0, SERVE, 1,1,0, 0,0);
    vecs[20] = v(0,0,0, SERVE, 1,1,0, 0,1);
    vecs[21] = v(0,0,0, SERVE, 1,1,0, 0,1);
    vecs[22] = v(0,0,0, SERVE, 1,1,0, 0,1);
    vecs[23] = v(0,0,0, PLAY,  1,1,0, 1,1);
    vecs[24] = v(0,0,1, POINT, 1,2,0, 0,1);
    vecs[25] = v(0,0,1, SERVE, 1,2,0, 0,0);
    vecs[26] = v(0,0,0, SERVE, 1,2,0, 0,1);
    vecs[27] = v(0,0,0, SERVE, 1,2,0, 0,1);
    vecs[28] = v(0,0,0, SERVE, 1,2,0, 0,1);
    vecs[29] = v(0,0,0, PLAY,  1,2,0, 1,1);
    vecs[30] = v(0,0,1, POINT, 1,3,0, 0,1);
    vecs[31] = v(0,0,0, OVER,  1,3,2, 0,1);
    vecs[32] = v(0,1,0, OVER,  1,3,2, 0,1);
    vecs[33] = v(1,0,0, SERVE, 0,0,0, 0,0);

    reset = 1'b0; start_btn = 0; player1_point = 0; player2_point = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b1;

    for (int i = 0; i < 34; i++) begin
      step(vecs[i].s, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d.state", i),        int'(state),        vecs[i].st);
      check($sformatf("vec%0d.score1", i),       int'(score1),       vecs[i].s1);
      check($sformatf("vec%0d.score2", i),       int'(score2),       vecs[i].s2);
      check($sformatf("vec%0d.winner", i),       int'(winner),       vecs[i].w);
      check($sformatf("vec%0d.game_on", i),      int'(game_on),      vecs[i].go);
      check($sformatf("vec%0d.ball_reset_n", i), int'(ball_reset_n), vecs[i].brn);
    end

    // Score a point, then reset two cycles into the following serve.
    repeat (4) begin step(0, 0, 0); check_model("seq_serve"); end
    step(0, 1, 0); check_model("seq_point");
    check("seq_point.score1", int'(score1), 1);
    step(0, 0, 0); check_model("seq_reserve");
    step(0, 0, 0); check_model("seq_reserve2");
    pulse_reset("mid_reset");
    for (int i = 0; i < 5; i++) begin
      step(0, i[0], ~i[0]);
      check_model("post_reset");
      check("post_reset.idle", int'(state), int'(IDLE));
    end
    step(1, 0, 0); check_model("restart");
    check("restart.state", int'(state), int'(SERVE));

    rs = 1; ra = 0; rb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset("rand_reset");
      if ($urandom_range(0, 15) == 0) rs = ~rs;
      if ($urandom_range(0, 5) == 0)  ra = ~ra;
      if ($urandom_range(0, 5) == 0)  rb = ~rb;
      step(rs, ra, rb);
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Match controller for the Pong datapath. It consumes the ball tracker's per-player point flags and drives the tracker's `game_on` enable and re-center reset. It keeps both scores, sequences serve, play, point and game-over, and declares a winner. It sits between the start button input, the ball tracker and the score display.

## Interface
Parameters:
- WIN_SCORE, 7: points needed to win; legal range 1..15.
- SERVE_DELAY, 50_000_000: cycles spent in SERVE before play; 1 s at 50 MHz; minimum 1.

Ports:
- clk  in  1  master 50 MHz clock.
- reset  in  1  asynchronous, active-low.
- start_btn  in  1  already synchronized and debounced, active-high level.
- player1_point  in  1  from the ball tracker; level, sticky until the ball is reset.
- player2_point  in  1  from the ball tracker; level, sticky until the ball is reset.
- game_on  out  1  ball motion enable to the tracker.
- ball_reset_n  out  1  active-low one-cycle pulse that re-centers the ball and clears the tracker's point flags.
- score1  out  4  player 1 score.
- score2  out  4  player 2 score.
- winner  out  2  00 none, 01 player 1, 10 player 2.
- state  out  3  current game_state_t, for the display.

## Operation
- **Edge detection.** `start_btn`, `player1_point` and `player2_point` each pass through a rising-edge detector. A registered previous value is compared with the current sample. Only edges act; levels are ignored.
- **FSM states:** IDLE, SERVE, PLAY, POINT, OVER.
- **IDLE.** Entered on reset. A start edge goes to SERVE with both scores cleared.
- **SERVE.**
  - `ball_reset_n` is low for exactly the first cycle of SERVE.
  - The serve counter loads SERVE_DELAY-1 on entry and counts down.
  - At 0 the FSM goes to PLAY.
- **PLAY.**
  - A p1 edge alone increments score1 and goes to POINT.
  - A p2 edge alone increments score2 and goes to POINT.
  - Both edges in the same cycle: neither score changes, and the FSM goes directly to SERVE (replay).
- **POINT.** Lasts one cycle.
  - If score1 equals WIN_SCORE: winner<=01, go to OVER.
  - Else if score2 equals WIN_SCORE: winner<=10, go to OVER.
  - Otherwise go to SERVE.
- **OVER.** Scores and winner are held. A start edge clears scores and winner and goes to SERVE.
- **Ignored edges.** Point edges outside PLAY are ignored. Start edges outside IDLE and OVER are ignored.
- **Arithmetic.** Scores are 4-bit unsigned. They never exceed WIN_SCORE, so no wrap is possible. The serve counter is 26 bits wide, sized by $clog2(SERVE_DELAY).
- **Reset.** Reset mid-match, in any state, asynchronously returns to IDLE and clears all outputs.

## Timing
- **Reset values:**
  - game_on=0
  - ball_reset_n=1
  - score1=0, score2=0
  - winner=00
  - state=IDLE
  - all edge-detector previous registers=0
- **Outputs are registered.** `game_on` is 1 exactly while state is PLAY.
- **Point latency:**
  - Point input first sampled high at edge k gives state=POINT, incremented score and game_on=0 after edge k.
  - SERVE or OVER follows after edge k+1.
  - `ball_reset_n`=0 from edge k+1 to edge k+2 (when going to SERVE).
- **Serve timing.** SERVE lasts exactly SERVE_DELAY cycles. game_on rises on the edge that ends the last SERVE cycle.
- **Start latency.** A start edge sampled at edge k gives state=SERVE and ball_reset_n=0 after edge k.
- **Point-flag rearming.**
  - The tracker's point flags drop after the reset pulse. This re-arms the detectors without a false edge.
  - A point line still high on entry to PLAY produces no edge.

## Structure
- **Package `pong_pkg`:**
  - `game_state_t` enum (3 bits: IDLE, SERVE, PLAY, POINT, OVER)
  - SCORE_W=4
  - X_RESOLUTION=640, Y_RESOLUTION=480
  - winner encoding constants WIN_NONE, WIN_P1, WIN_P2
- **Sub-module `rise_detect`:** one register and an AND gate, with async active-low reset. Instantiated three times.
- **Top-level RTL:** FSM, serve counter and score registers. Roughly 150-200 lines.

## Test plan
Run all scenarios with SERVE_DELAY=4 and WIN_SCORE=3.
- **Start from IDLE:** reset, then pulse start_btn for 1 cycle -> next cycle state=SERVE and ball_reset_n=0 for 1 cycle; game_on=1 exactly 4 cycles after SERVE entry.
- **Single point:** in PLAY, raise player1_point and hold it -> after 1 edge score1=1 and game_on=0; the next cycle is SERVE with ball_reset_n low once. The held level causes no second increment.
- **Simultaneous points:** in PLAY, raise player1_point and player2_point in the same cycle -> scores unchanged, direct SERVE, ball_reset_n pulsed.
- **Match win:** player2 scores 3 times -> score2=3, winner=10, state=OVER, game_on stays 0. Further point edges are ignored. A start edge gives score1=score2=0, winner=00, SERVE.
- **Reset mid-operation:** assert reset during SERVE while the counter is at 2 -> immediately state=IDLE, game_on=0, scores 0. After deassert, no action occurs until a start edge.
- **Ignored start edges:** a start edge during PLAY and during SERVE -> no state change and no score clear.
